n_bit_latch_bank: RTL and testbench
===================================

# n_bit_latch_bank

Parametrised bank of N-bit output latches with asynchronous active-low clear: CHANNELS independent registers, each written by address with load/set/clear/toggle operations, optionally double-buffered so that a single commit strobe updates all outputs on the same edge. It is the next-generation replacement for single-register port latches on the SBC I/O decode path (LED/port/bank-select registers). It also provides registered readback for CPU IN cycles.

## Interface
- WIDTH, 8, bits per channel
- CHANNELS, 4, number of latch channels (≥1, need not be a power of two)
- AW, 2, address width; 2^AW ≥ CHANNELS
- BUFFERED, 1, 1 = writes go to staging and take effect on commit; 0 = writes go straight to outputs
- RESET_VAL, 0, WIDTH-bit value loaded into every output and staging register on clear

- clk  in  1  system clock, all state on rising edge
- clr  in  1  asynchronous, active-low reset
- we  in  1  write strobe, one write per cycle when high
- addr  in  AW  target channel
- op  in  2  00 load, 01 set bits (OR), 10 clear bits (AND NOT), 11 toggle (XOR)
- inData  in  WIDTH  write operand
- commit  in  1  copy all dirty staging registers to outputs (ignored when BUFFERED=0)
- flush  in  1  discard staged writes (ignored when BUFFERED=0)
- rd_addr  in  AW  readback channel
- rd_stage  in  1  readback source: 1 = staging, 0 = output
- regOut  out  CHANNELS*WIDTH  output registers, channel k at bits [k*WIDTH +: WIDTH]
- rd_data  out  WIDTH  registered readback
- dirty  out  CHANNELS  per-channel staged-but-uncommitted flag
- commit_done  out  1  one-cycle pulse after a commit that moved ≥1 channel

## Operation
- Clear (clr low, asynchronous, any time): every regOut channel and staging register = RESET_VAL, dirty = 0, rd_data = 0, commit_done = 0. Held while clr low. A write, commit or flush pending at the edge is lost.
- Write target value: load → inData; set → cur | inData; clear → cur & ~inData; toggle → cur ^ inData. cur is staging[addr] when BUFFERED=1 and regOut[addr] when BUFFERED=0.
- BUFFERED=0: regOut[addr] updated at the write edge. dirty stays 0. commit_done stays 0.
- BUFFERED=1: staging[addr] updated and dirty[addr] set. On commit, every channel with dirty=1 copies staging to regOut and its dirty bit clears, all on one edge. Clean channels are untouched.
- commit_done = 1 the cycle after a commit edge at which dirty was nonzero. A commit with dirty = 0 does nothing and does not pulse.
- flush: staging[k] = regOut[k] for every k, dirty = 0. commit and flush in the same cycle: commit wins and flush is ignored.
- Write and commit in the same cycle: commit uses pre-write staging values. The write then lands in staging with its dirty bit set, so it is not lost and waits for the next commit.
- Write and flush in the same cycle: flush applies to all channels except addr. addr receives the write, computed against the pre-flush staging value, with dirty set.
- addr ≥ CHANNELS: write ignored, no state change. rd_addr ≥ CHANNELS: rd_data = 0.
- Readback: rd_data registered each cycle from the selected source at rd_addr. rd_stage is ignored when BUFFERED=0, where the output is always read.

## Timing
- Write→regOut latency: 1 edge (BUFFERED=0). Write→staging: 1 edge. commit→regOut: 1 edge.
- Readback latency: 1 cycle. A value written at edge t is visible on rd_data after edge t+1.
- commit_done is asserted for exactly one cycle, following the commit edge.
- No combinational path from inputs to any output. All outputs are registered.
- Back-to-back writes to the same channel on consecutive cycles chain, and each operation sees the previous result.

## Test plan
- Reset: drive clr low mid-run with RESET_VAL=8'hA5 → all regOut channels = A5, dirty = 0, rd_data = 0 immediately, before the next clk edge.
- BUFFERED=0 ops: load 0x0F to ch2, then set 0xF0, clear 0x3C, toggle 0xFF → regOut ch2 = 0F, FF, C3, 3C on successive edges; other channels unchanged.
- BUFFERED=1 atomic commit:
  - Write ch0 = 0x11 and ch3 = 0x33 → regOut unchanged, dirty = 4'b1001.
  - Assert commit → both channels update on the same edge, dirty = 0, commit_done pulses once.
  - A second commit → no pulse.
- Simultaneous write and commit: staging ch1 = 0x22 (dirty), then write ch1 = 0x44 with commit in the same cycle → regOut ch1 = 0x22, staging ch1 = 0x44, dirty[1] = 1.
- Flush and write collisions:
  - Stage ch0 = 0x55 and ch1 = 0x66, then flush with a simultaneous write of ch1 = 0x77 → staging ch0 = regOut ch0, dirty[0] = 0, staging ch1 = 0x77, dirty[1] = 1.
  - Flush and commit together → commit behaviour only.
- CHANNELS=3, AW=2: write addr 3 → no change anywhere. rd_addr = 3 → rd_data = 0. Readback of ch2 with rd_stage 0/1 returns regOut/staging one cycle later.

Source files
------------

// File: rtl/n_bit_latch_bank.sv
// Addressable bank of output latches with load/set/clear/toggle writes,
// optional staging with atomic commit/flush, and registered readback.
module n_bit_latch_bank #(
  parameter int              WIDTH     = 8,
  parameter int              CHANNELS  = 4,
  parameter int              AW        = 2,
  parameter int              BUFFERED  = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic                      we,
  input  logic [AW-1:0]             addr,
  input  logic [1:0]                op,
  input  logic [WIDTH-1:0]          inData,
  input  logic                      commit,
  input  logic                      flush,
  input  logic [AW-1:0]             rd_addr,
  input  logic                      rd_stage,
  output logic [CHANNELS*WIDTH-1:0] regOut,
  output logic [WIDTH-1:0]          rd_data,
  output logic [CHANNELS-1:0]       dirty,
  output logic                      commit_done
);

  localparam logic [1:0] OP_LOAD   = 2'b00;
  localparam logic [1:0] OP_SET    = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;
  localparam bit         BUF_EN    = (BUFFERED != 0);

  function automatic logic [WIDTH-1:0] apply_op(input logic [1:0] op_i,
                                                input logic [WIDTH-1:0] cur_i,
                                                input logic [WIDTH-1:0] d_i);
    logic [WIDTH-1:0] res;
    case (op_i)
      OP_LOAD:   res = d_i;
      OP_SET:    res = cur_i | d_i;
      OP_CLEAR:  res = cur_i & ~d_i;
      OP_TOGGLE: res = cur_i ^ d_i;
      default:   res = cur_i;
    endcase
    return res;
  endfunction

  logic [WIDTH-1:0]    r_out       [CHANNELS];
  logic [WIDTH-1:0]    r_stage     [CHANNELS];
  logic [CHANNELS-1:0] r_dirty;
  logic [WIDTH-1:0]    r_rd_data;
  logic                r_commit_done;

  logic [WIDTH-1:0]    w_out_nxt   [CHANNELS];
  logic [WIDTH-1:0]    w_stage_nxt [CHANNELS];
  logic [CHANNELS-1:0] w_dirty_nxt;
  logic [CHANNELS-1:0] w_hit;
  logic [WIDTH-1:0]    w_cur;
  logic [WIDTH-1:0]    w_wval;
  logic [WIDTH-1:0]    w_rd_nxt;
  logic                w_commit;
  logic                w_flush;
  logic                w_commit_done_nxt;

  // Write decode and target-value computation; out-of-range addresses match no channel
  always_comb begin
    w_cur = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      w_hit[k] = we && (addr == AW'(k));
      w_cur    = w_cur | (w_hit[k] ? (BUF_EN ? r_stage[k] : r_out[k]) : '0);
    end
    w_wval            = apply_op(op, w_cur, inData);
    w_commit          = BUF_EN && commit;
    w_flush           = BUF_EN && flush && !commit;
    w_commit_done_nxt = w_commit && (|r_dirty);
  end

  // Per-channel next state; a colliding write overrides the flush for its own channel
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      if (BUF_EN) begin
        w_out_nxt[k]   = (w_commit && r_dirty[k]) ? r_stage[k] : r_out[k];
        w_stage_nxt[k] = w_hit[k] ? w_wval : (w_flush ? r_out[k] : r_stage[k]);
        w_dirty_nxt[k] = w_hit[k] ? 1'b1 : ((w_commit || w_flush) ? 1'b0 : r_dirty[k]);
      end else begin
        w_out_nxt[k]   = w_hit[k] ? w_wval : r_out[k];
        w_stage_nxt[k] = r_stage[k];
        w_dirty_nxt[k] = 1'b0;
      end
    end
  end

  // Readback mux; unmapped channels read as zero
  always_comb begin
    w_rd_nxt = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      w_rd_nxt = w_rd_nxt | ((rd_addr == AW'(k)) ?
                             ((BUF_EN && rd_stage) ? r_stage[k] : r_out[k]) : '0);
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int k = 0; k < CHANNELS; k++) begin
        r_out[k]   <= RESET_VAL;
        r_stage[k] <= RESET_VAL;
      end
      r_dirty       <= '0;
      r_rd_data     <= '0;
      r_commit_done <= 1'b0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        r_out[k]   <= w_out_nxt[k];
        r_stage[k] <= w_stage_nxt[k];
      end
      r_dirty       <= w_dirty_nxt;
      r_rd_data     <= w_rd_nxt;
      r_commit_done <= w_commit_done_nxt;
    end
  end

  genvar g;
  generate
    for (g = 0; g < CHANNELS; g++) begin : g_pack
      assign regOut[g*WIDTH +: WIDTH] = r_out[g];
    end
  endgenerate

  assign rd_data     = r_rd_data;
  assign dirty       = r_dirty;
  assign commit_done = r_commit_done;

endmodule

// File: tb/tb_n_bit_latch_bank.sv
// Directed bench: unbuffered 4ch, buffered 4ch and buffered 3ch banks on shared stimulus.
module tb_n_bit_latch_bank;

  logic       clk = 1'b0;
  logic       clr;
  logic       we;
  logic [1:0] addr;
  logic [1:0] op;
  logic [7:0] inData;
  logic       commit;
  logic       flush;
  logic [1:0] rd_addr;
  logic       rd_stage;

  logic [31:0] out0, out1;
  logic [23:0] out2;
  logic [7:0]  rd0, rd1, rd2;
  logic [3:0]  dirty0, dirty1;
  logic [2:0]  dirty2;
  logic        cd0, cd1, cd2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  n_bit_latch_bank #(.WIDTH(8), .CHANNELS(4), .AW(2), .BUFFERED(0), .RESET_VAL(8'hA5)) u_unbuf (
    .clk(clk), .clr(clr), .we(we), .addr(addr), .op(op), .inData(inData),
    .commit(commit), .flush(flush), .rd_addr(rd_addr), .rd_stage(rd_stage),
    .regOut(out0), .rd_data(rd0), .dirty(dirty0), .commit_done(cd0));

  n_bit_latch_bank #(.WIDTH(8), .CHANNELS(4), .AW(2), .BUFFERED(1), .RESET_VAL(8'hA5)) u_buf (
    .clk(clk), .clr(clr), .we(we), .addr(addr), .op(op), .inData(inData),
    .commit(commit), .flush(flush), .rd_addr(rd_addr), .rd_stage(rd_stage),
    .regOut(out1), .rd_data(rd1), .dirty(dirty1), .commit_done(cd1));

  n_bit_latch_bank #(.WIDTH(8), .CHANNELS(3), .AW(2), .BUFFERED(1), .RESET_VAL(8'hA5)) u_buf3 (
    .clk(clk), .clr(clr), .we(we), .addr(addr), .op(op), .inData(inData),
    .commit(commit), .flush(flush), .rd_addr(rd_addr), .rd_stage(rd_stage),
    .regOut(out2), .rd_data(rd2), .dirty(dirty2), .commit_done(cd2));

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [1:0] o, input logic [7:0] d);
    we = 1'b1; addr = a; op = o; inData = d;
  endtask

  initial begin
    clr = 1'b0; we = 1'b0; addr = 2'd0; op = 2'd0; inData = 8'h00;
    commit = 1'b0; flush = 1'b0; rd_addr = 2'd0; rd_stage = 1'b0;
    #12;
    check_val("rst_out0", out0, 32'hA5A5A5A5);
    check_val("rst_rd0", {24'h0, rd0}, 32'h0);
    check_val("rst_dirty1", {28'h0, dirty1}, 32'h0);
    @(negedge clk); clr = 1'b1;

    // unbuffered op chain on ch2
    @(negedge clk); wr(2'd2, 2'b00, 8'h0F); rd_addr = 2'd2;
    step(); check_val("ub_load", out0, 32'hA50FA5A5);
    wr(2'd2, 2'b01, 8'hF0);
    step(); check_val("ub_set", out0, 32'hA5FFA5A5);
    wr(2'd2, 2'b10, 8'h3C);
    step(); check_val("ub_clear", out0, 32'hA5C3A5A5);
    wr(2'd2, 2'b11, 8'hFF);
    step(); check_val("ub_toggle", out0, 32'hA53CA5A5);
    check_val("ub_dirty", {28'h0, dirty0}, 32'h0);
    we = 1'b0; flush = 1'b1;
    step(); check_val("ub_rd", {24'h0, rd0}, 32'h3C);
    check_val("ub_cd", {31'h0, cd0}, 32'h0);
    check_val("flush_dirty1", {28'h0, dirty1}, 32'h0);
    flush = 1'b0;

    // buffered atomic commit
    wr(2'd0, 2'b00, 8'h11); step();
    wr(2'd3, 2'b00, 8'h33); step();
    we = 1'b0;
    check_val("stage_out1", out1, 32'hA5A5A5A5);
    check_val("stage_dirty", {28'h0, dirty1}, 32'h9);
    commit = 1'b1;
    step(); check_val("commit_out", out1, 32'h33A5A511);
    check_val("commit_dirty", {28'h0, dirty1}, 32'h0);
    check_val("commit_pulse", {31'h0, cd1}, 32'h1);
    step(); check_val("commit2_nopulse", {31'h0, cd1}, 32'h0);
    commit = 1'b0;
    step(); check_val("cd_idle", {31'h0, cd1}, 32'h0);

    // write + commit collision on ch1
    wr(2'd1, 2'b00, 8'h22); step();
    wr(2'd1, 2'b00, 8'h44); commit = 1'b1; rd_addr = 2'd1; rd_stage = 1'b1;
    step(); check_val("wc_out", out1, 32'h33A52211);
    check_val("wc_dirty", {28'h0, dirty1}, 32'h2);
    we = 1'b0; commit = 1'b0;
    step(); check_val("wc_stage", {24'h0, rd1}, 32'h44);
    commit = 1'b1;
    step(); check_val("wc_commit2", out1, 32'h33A54411);
    check_val("wc_pulse", {31'h0, cd1}, 32'h1);
    commit = 1'b0;

    // flush + write collision
    wr(2'd0, 2'b00, 8'h55); step();
    wr(2'd1, 2'b00, 8'h66); step();
    wr(2'd1, 2'b00, 8'h77); flush = 1'b1;
    step(); check_val("fw_dirty", {28'h0, dirty1}, 32'h2);
    check_val("fw_out", out1, 32'h33A54411);
    we = 1'b0; flush = 1'b0; rd_addr = 2'd0; rd_stage = 1'b1;
    step(); check_val("fw_stage0", {24'h0, rd1}, 32'h11);
    rd_addr = 2'd1;
    step(); check_val("fw_stage1", {24'h0, rd1}, 32'h77);

    // flush + commit: commit wins
    commit = 1'b1; flush = 1'b1;
    step(); check_val("fc_out", out1, 32'h33A57711);
    check_val("fc_dirty", {28'h0, dirty1}, 32'h0);
    check_val("fc_pulse", {31'h0, cd1}, 32'h1);
    commit = 1'b0; flush = 1'b0;

    // asynchronous clear mid-cycle
    step(); #2; clr = 1'b0; #1;
    check_val("arst_out0", out0, 32'hA5A5A5A5);
    check_val("arst_out1", out1, 32'hA5A5A5A5);
    check_val("arst_dirty", {28'h0, dirty1}, 32'h0);
    check_val("arst_rd", {24'h0, rd1}, 32'h0);
    @(negedge clk); clr = 1'b1;

    // 3-channel bank: unmapped address and readback
    wr(2'd3, 2'b00, 8'hFF); rd_addr = 2'd3; rd_stage = 1'b0;
    step(); check_val("c3_oor_out", {8'h0, out2}, 32'h00A5A5A5);
    check_val("c3_oor_dirty", {29'h0, dirty2}, 32'h0);
    we = 1'b0;
    step(); check_val("c3_oor_rd", {24'h0, rd2}, 32'h0);
    wr(2'd2, 2'b00, 8'h5A); step();
    we = 1'b0; commit = 1'b1;
    step(); check_val("c3_commit", {8'h0, out2}, 32'h005AA5A5);
    commit = 1'b0;
    wr(2'd2, 2'b01, 8'h0F); step();
    we = 1'b0; rd_addr = 2'd2; rd_stage = 1'b0;
    step(); check_val("c3_rd_out", {24'h0, rd2}, 32'h5A);
    rd_stage = 1'b1;
    step(); check_val("c3_rd_stage", {24'h0, rd2}, 32'h5F);
    check_val("c3_dirty", {29'h0, dirty2}, 32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
